// File: rtl/mfcc_feature_buffer_pkg.sv
// Shared definitions for the MFCC feature ping-pong buffer: FSM encoding and
// default geometry.
package mfcc_feature_buffer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } mfcc_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 128;

endpackage : mfcc_feature_buffer_pkg

// File: rtl/mfcc_feature_buffer_bank_ram.sv
// One frame bank: single-clock RAM, one write port and one registered read port
// whose output register resets to zero (the array itself is never cleared).
module mfcc_bank_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Storage array write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mfcc_bank_ram

// File: rtl/mfcc_feature_buffer.sv
// Two-bank ping-pong feature buffer between a PIO producer and a network
// consumer; the FSM counts committed banks (EMPTY / ONE / FULL).
module mfcc_feature_buffer
    import mfcc_feature_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              frame_commit,
    output logic              wr_ready,
    output logic              overflow,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_valid,
    output logic [ADDR_W:0]   frame_len,
    input  logic              frame_release
);

    mfcc_state_e           r_state;
    mfcc_state_e           w_state_nxt;
    logic                  r_fb;
    logic                  r_sb;
    logic                  w_fb_nxt;
    logic                  w_sb_nxt;
    logic                  w_fb_inv;
    logic [1:0][ADDR_W:0]  r_len;
    logic [1:0][ADDR_W:0]  w_len_nxt;
    logic                  r_wr_en_q;
    logic                  r_commit_q;
    logic                  w_wr_edge;
    logic                  w_commit_edge;
    logic                  w_wr_ok;
    logic                  w_drop;
    logic                  w_valid_nxt;
    logic [ADDR_W:0]       w_wr_len;
    logic                  r_wr_ready;
    logic                  r_overflow;
    logic                  r_frame_valid;
    logic [ADDR_W:0]       r_frame_len;
    logic                  r_rd_sel;
    logic [DATA_W-1:0]     w_rd_data0;
    logic [DATA_W-1:0]     w_rd_data1;

    assign w_wr_edge     = wr_en & ~r_wr_en_q;
    assign w_commit_edge = frame_commit & ~r_commit_q;
    assign w_wr_ok       = w_wr_edge & (r_state != ST_FULL);
    assign w_drop        = (r_state == ST_FULL) & (w_wr_edge | w_commit_edge);
    assign w_wr_len      = {1'b0, wr_addr} + {{ADDR_W{1'b0}}, 1'b1};
    assign w_fb_inv      = ~r_fb;

    // Edge-detect registers for the level strobes
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_wr_en_q  <= 1'b0;
            r_commit_q <= 1'b0;
        end else begin
            r_wr_en_q  <= wr_en;
            r_commit_q <= frame_commit;
        end
    end

    // Next-state, bank pointers and per-bank lengths
    always_comb begin
        w_state_nxt = r_state;
        w_fb_nxt    = r_fb;
        w_sb_nxt    = r_sb;
        w_len_nxt   = r_len;
        // The write is applied first so a same-cycle commit carries it along
        if (w_wr_ok && (w_wr_len > r_len[r_fb])) begin
            w_len_nxt[r_fb] = w_wr_len;
        end else begin
            w_len_nxt[r_fb] = r_len[r_fb];
        end
        case (r_state)
            ST_EMPTY: begin
                if (w_commit_edge) begin
                    w_state_nxt         = ST_ONE;
                    w_sb_nxt            = r_fb;
                    w_fb_nxt            = w_fb_inv;
                    w_len_nxt[w_fb_inv] = '0;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_commit_edge && frame_release) begin
                    w_state_nxt         = ST_ONE;
                    w_sb_nxt            = r_fb;
                    w_fb_nxt            = w_fb_inv;
                    w_len_nxt[w_fb_inv] = '0;
                end else if (w_commit_edge) begin
                    // Fill pointer stays put: no free bank until a release
                    w_state_nxt = ST_FULL;
                end else if (frame_release) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                if (frame_release) begin
                    w_state_nxt     = ST_ONE;
                    w_sb_nxt        = ~r_sb;
                    w_fb_nxt        = r_sb;
                    w_len_nxt[r_sb] = '0;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_fb_nxt    = 1'b0;
                w_sb_nxt    = 1'b0;
                w_len_nxt   = '0;
            end
        endcase
    end

    assign w_valid_nxt = (w_state_nxt != ST_EMPTY);

    // State, pointers and lengths
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_EMPTY;
            r_fb    <= 1'b0;
            r_sb    <= 1'b0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fb    <= w_fb_nxt;
            r_sb    <= w_sb_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Status outputs registered from next-state values
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_wr_ready    <= 1'b1;
            r_overflow    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_len   <= '0;
            r_rd_sel      <= 1'b0;
        end else begin
            r_wr_ready    <= (w_state_nxt != ST_FULL);
            r_overflow    <= r_overflow | w_drop;
            r_frame_valid <= w_valid_nxt;
            r_frame_len   <= w_valid_nxt ? w_len_nxt[w_sb_nxt] : '0;
            r_rd_sel      <= r_sb;
        end
    end

    mfcc_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_we    (w_wr_ok & ~r_fb),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (rd_addr),
        .o_rdata (w_rd_data0)
    );

    mfcc_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
        .i_clk   (CLOCK_50),
        .i_rst   (RESET),
        .i_we    (w_wr_ok & r_fb),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (rd_addr),
        .o_rdata (w_rd_data1)
    );

    assign rd_data     = r_rd_sel ? w_rd_data1 : w_rd_data0;
    assign wr_ready    = r_wr_ready;
    assign overflow    = r_overflow;
    assign frame_valid = r_frame_valid;
    assign frame_len   = r_frame_len;

endmodule : mfcc_feature_buffer

// File: tb/tb_mfcc_feature_buffer.sv
// Directed self-checking bench for mfcc_feature_buffer (default and 16x16 builds).
module tb_mfcc_feature_buffer;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic [6:0]  wr_addr  = 7'd0;
    logic [31:0] wr_data  = 32'd0;
    logic        wr_en    = 1'b0;
    logic        frame_commit  = 1'b0;
    logic        frame_release = 1'b0;
    logic [6:0]  rd_addr  = 7'd0;
    logic        wr_ready;
    logic        overflow;
    logic [31:0] rd_data;
    logic        frame_valid;
    logic [7:0]  frame_len;

    logic [3:0]  s_wr_addr = 4'd0;
    logic [15:0] s_wr_data = 16'd0;
    logic        s_wr_en   = 1'b0;
    logic        s_commit  = 1'b0;
    logic        s_release = 1'b0;
    logic [3:0]  s_rd_addr = 4'd0;
    logic        s_wr_ready;
    logic        s_overflow;
    logic [15:0] s_rd_data;
    logic        s_frame_valid;
    logic [4:0]  s_frame_len;

    int n_vec = 0;
    int n_err = 0;

    mfcc_feature_buffer dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .frame_commit(frame_commit), .wr_ready(wr_ready),
        .overflow(overflow), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_len(frame_len), .frame_release(frame_release)
    );

    mfcc_feature_buffer #(.DATA_W(16), .DEPTH(16)) dut_small (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .wr_en(s_wr_en), .frame_commit(s_commit), .wr_ready(s_wr_ready),
        .overflow(s_overflow), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .frame_valid(s_frame_valid), .frame_len(s_frame_len), .frame_release(s_release)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic write_word(input logic [6:0] a, input logic [31:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic commit_frame();
        frame_commit = 1'b1;
        tick();
        frame_commit = 1'b0;
        tick();
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        tick();
    endtask

    task automatic read_word(input logic [6:0] a, output logic [31:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(); tick();
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", frame_valid); end
        n_vec++; if (frame_len !== 8'd0) begin n_err++; $display("FAIL reset_len: got %0d expected 0", frame_len); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b expected 1", wr_ready); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
        n_vec++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL reset_rd: got %h expected 0", rd_data); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [31:0] d;
        for (int i = 0; i < 13; i++) write_word(7'(i), 32'hA5A50000 + 32'(i));
        frame_commit = 1'b1;
        tick();
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b expected 1", frame_valid); end
        n_vec++; if (frame_len !== 8'd13) begin n_err++; $display("FAIL basic_len: got %0d expected 13", frame_len); end
        frame_commit = 1'b0;
        tick();
        read_word(7'd5, d);
        n_vec++; if (d !== 32'hA5A50005) begin n_err++; $display("FAIL basic_rd5: got %h expected a5a50005", d); end
        read_word(7'd12, d);
        n_vec++; if (d !== 32'hA5A5000C) begin n_err++; $display("FAIL basic_rd12: got %h expected a5a5000c", d); end
        release_frame();
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL basic_rel_valid: got %0b expected 0", frame_valid); end
        n_vec++; if (frame_len !== 8'd0) begin n_err++; $display("FAIL basic_rel_len: got %0d expected 0", frame_len); end
    endtask

    task automatic test_held_write();
        logic [31:0] d;
        wr_addr = 7'd3; wr_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_data = 32'h00001000 + 32'(k);
            tick();
        end
        wr_en = 1'b0;
        tick();
        commit_frame();
        n_vec++; if (frame_len !== 8'd4) begin n_err++; $display("FAIL held_len: got %0d expected 4", frame_len); end
        read_word(7'd3, d);
        n_vec++; if (d !== 32'h00001000) begin n_err++; $display("FAIL held_data: got %h expected 00001000", d); end
        release_frame();
    endtask

    task automatic test_write_commit();
        logic [31:0] d;
        write_word(7'd2, 32'h11112222);
        wr_addr = 7'd9; wr_data = 32'h33334444; wr_en = 1'b1; frame_commit = 1'b1;
        tick();
        wr_en = 1'b0; frame_commit = 1'b0;
        n_vec++; if (frame_len !== 8'd10) begin n_err++; $display("FAIL wc_len: got %0d expected 10", frame_len); end
        tick();
        read_word(7'd9, d);
        n_vec++; if (d !== 32'h33334444) begin n_err++; $display("FAIL wc_rd9: got %h expected 33334444", d); end
        read_word(7'd2, d);
        n_vec++; if (d !== 32'h11112222) begin n_err++; $display("FAIL wc_rd2: got %h expected 11112222", d); end
        release_frame();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        write_word(7'd1, 32'hCAFE0001);
        commit_frame();
        n_vec++; if (frame_len !== 8'd2) begin n_err++; $display("FAIL b2b_first_len: got %0d expected 2", frame_len); end
        write_word(7'd5, 32'hCAFE0005);
        frame_commit = 1'b1; frame_release = 1'b1;
        tick();
        frame_commit = 1'b0; frame_release = 1'b0;
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %0b expected 1", frame_valid); end
        n_vec++; if (frame_len !== 8'd6) begin n_err++; $display("FAIL b2b_len: got %0d expected 6", frame_len); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %0b expected 0", overflow); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %0b expected 1", wr_ready); end
        tick();
        read_word(7'd5, d);
        n_vec++; if (d !== 32'hCAFE0005) begin n_err++; $display("FAIL b2b_rd5: got %h expected cafe0005", d); end
        release_frame();
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %0b expected 0", frame_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        write_word(7'd3, 32'h0000AAAA);
        commit_frame();
        write_word(7'd7, 32'h0000BBBB);
        commit_frame();
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_full_ready: got %0b expected 0", wr_ready); end
        n_vec++; if (frame_len !== 8'd4) begin n_err++; $display("FAIL ovf_full_len: got %0d expected 4", frame_len); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %0b expected 0", overflow); end
        write_word(7'd15, 32'h0000CCCC);
        commit_frame();
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready: got %0b expected 0", wr_ready); end
        release_frame();
        n_vec++; if (frame_len !== 8'd8) begin n_err++; $display("FAIL ovf_rel_len: got %0d expected 8", frame_len); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL ovf_rel_ready: got %0b expected 1", wr_ready); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
        read_word(7'd7, d);
        n_vec++; if (d !== 32'h0000BBBB) begin n_err++; $display("FAIL ovf_rd7: got %h expected 0000bbbb", d); end
    endtask

    task automatic test_reset_full();
        write_word(7'd0, 32'h12345678);
        commit_frame();
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rf_full: got %0b expected 0", wr_ready); end
        RESET = 1'b1;
        tick();
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid: got %0b expected 0", frame_valid); end
        n_vec++; if (frame_len !== 8'd0) begin n_err++; $display("FAIL rf_len: got %0d expected 0", frame_len); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rf_ready: got %0b expected 1", wr_ready); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rf_ovf: got %0b expected 0", overflow); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_small_geometry();
        s_wr_addr = 4'd15; s_wr_data = 16'hBEEF; s_wr_en = 1'b1;
        tick();
        s_wr_en = 1'b0;
        tick();
        s_commit = 1'b1;
        tick();
        s_commit = 1'b0;
        n_vec++; if (s_frame_len !== 5'd16) begin n_err++; $display("FAIL small_len: got %0d expected 16", s_frame_len); end
        n_vec++; if (s_frame_valid !== 1'b1) begin n_err++; $display("FAIL small_valid: got %0b expected 1", s_frame_valid); end
        s_rd_addr = 4'd15;
        tick();
        n_vec++; if (s_rd_data !== 16'hBEEF) begin n_err++; $display("FAIL small_rd: got %h expected beef", s_rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_held_write();
        test_write_commit();
        test_back_to_back();
        test_overflow();
        test_reset_full();
        test_small_geometry();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mfcc_feature_buffer

// File: doc/mfcc_feature_buffer.md
MFCC_FEATURE_BUFFER -- requirements
Module: mfcc_feature_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one feature word.
REQ-002 SHALL have parameter DEPTH, default 128: words per frame bank; power of two, 16..1024.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_addr  in  ADDR_W  producer (Nios PIO) word address.
REQ-007 SHALL have port wr_data  in  DATA_W  producer word.
REQ-008 SHALL have port wr_en  in  1  level write strobe; one write per rising edge.
REQ-009 SHALL have port frame_commit  in  1  level strobe; rising edge commits the fill bank.
REQ-010 SHALL have port wr_ready  out  1  high when a fill bank is free.
REQ-011 SHALL have port overflow  out  1  sticky: write or commit dropped while wr_ready=0.
REQ-012 SHALL have port rd_addr  in  ADDR_W  consumer (network) word address.
REQ-013 SHALL have port rd_data  out  DATA_W  word from the serve bank.
REQ-014 SHALL have port frame_valid  out  1  serve bank holds a committed frame.
REQ-015 SHALL have port frame_len  out  ADDR_W+1  word count of the served frame.
REQ-016 SHALL have port frame_release  in  1  one-cycle pulse; consumer done with the served frame.

Function
REQ-017 SHALL hold two banks of DEPTH x DATA_W, a fill pointer fb and a serve pointer sb (1 bit each).
REQ-018 SHALL edge-detect wr_en and frame_commit against a registered copy; held levels act once.
REQ-019 SHALL write wr_data to bank fb at wr_addr on the cycle a wr_en rising edge is seen, if wr_ready=1.
REQ-020 SHALL track a per-bank length = max(written wr_addr)+1, cleared when the bank becomes the fill bank.
REQ-021 SHALL run FSM EMPTY / ONE / FULL, giving the count of committed banks.
REQ-022 EMPTY: commit edge -> ONE, sb<=fb, fb<=~fb; frame_valid=0, wr_ready=1.
REQ-023 ONE: commit edge without release -> FULL (fb<=~fb deferred); release without commit -> EMPTY; both together -> ONE, sb<=old fb, fb<=~old fb.
REQ-024 FULL: release -> ONE, sb<=~sb, fb<=old sb (freed bank, length cleared); commit edge dropped and overflow<=1; wr_ready=0.
REQ-025 SHALL treat release in EMPTY as a no-op.
REQ-026 SHALL give rd_data with exactly one cycle latency (registered read of bank sb at rd_addr); rd_data is undefined-free: reads while EMPTY return the last stored value.
REQ-027 SHALL drop writes while wr_ready=0 and set overflow; overflow clears only on RESET.
REQ-028 SHALL include a write and a commit edge in the same cycle in the committed frame.
REQ-029 SHALL drive frame_len = length of bank sb when frame_valid=1, else 0.
REQ-030 SHALL never write bank sb while frame_valid=1.

Reset
REQ-031 SHALL, on RESET, set state EMPTY, fb=0, sb=0, lengths 0, edge registers 0, overflow=0, frame_valid=0, frame_len=0, wr_ready=1, rd_data=0; memory contents are not cleared.
REQ-032 SHALL abandon any partially filled or served frame when RESET asserts mid-operation.

Structure
REQ-033 SHALL place the FSM state encoding (EMPTY=0, ONE=1, FULL=2) and default DATA_W/DEPTH in the shared ASR package.
REQ-034 SHALL instantiate one sub-module, mfcc_bank_ram (single-clock, 1 write / 1 registered read port), once per bank.

Verification
REQ-035 Write 0xA5A50000+i at addr i=0..12, commit -> frame_valid=1 next cycle, frame_len=13, rd_addr=5 gives 0xA5A50005 one cycle later.
REQ-036 Hold wr_en high 10 cycles at addr 3 with data changing -> only first-edge data stored; frame_len=4 after commit.
REQ-037 Commit three frames (lens 4, 8, 16) with no release -> third commit dropped, overflow=1, wr_ready=0; release -> frame_len=8, wr_ready=1.
REQ-038 In ONE, pulse release and commit edge in the same cycle -> state stays ONE, frame_len switches to the new frame's length, no overflow.
REQ-039 Assert RESET while FULL -> next cycle frame_valid=0, frame_len=0, wr_ready=1, overflow=0.
REQ-040 DATA_W=16, DEPTH=16: write addr 15 only, commit -> frame_len=16, readback exact, addr width 4.
